mem_sequencer: RTL and testbench
================================

// Module: mem_sequencer
// PURPOSE
//  CPU-side bus sequencer; sits directly upstream of the memory block and drives its ADDR/DIN/RDN/WR0N/WR1N.
//  Accepts one word or byte request per REQ/ACK handshake and registers the address and write data.
//  Sequences the active-low strobes for a programmable number of cycles, then captures read data.
//  Steers byte lanes and zero/sign-extends byte reads before returning data with a one-cycle ACK.
// PARAMETERS
//  RD_WAIT  1  cycles RDN held low before DOUT is sampled (min 1; the RAM registers its output)
//  WR_WAIT  1  cycles WR0N/WR1N held low per write (min 1)
// PORTS
//  CLK        in   1   system clock; all state changes on rising edge
//  RESET      in   1   synchronous, active-high reset
//  CPU_REQ    in   1   request valid; held high until CPU_ACK
//  CPU_WE     in   1   1=write, 0=read
//  CPU_BYTE   in   1   1=byte access, 0=word access
//  CPU_HI     in   1   byte lane for byte access: 0=D[7:0] (WR0N), 1=D[15:8] (WR1N)
//  CPU_SEXT   in   1   byte read: 1=sign-extend, 0=zero-extend
//  CPU_ADDR   in   16  word address passed to memory ADDR
//  CPU_WDATA  in   16  write data; byte writes use CPU_WDATA[7:0]
//  CPU_RDATA  out  16  read result; valid in the cycle CPU_ACK=1, held until the next read completes
//  CPU_ACK    out  1   one-cycle completion pulse
//  BUSY       out  1   high in every state except IDLE
//  ADDR       out  16  to memory ADDR
//  DIN        out  16  to memory DIN
//  DOUT       in   16  from memory DOUT
//  RDN        out  1   read strobe, active low
//  WR0N       out  1   low-byte write strobe, active low
//  WR1N       out  1   high-byte write strobe, active low
// BEHAVIOUR
//  Reset: state=IDLE; RDN=WR0N=WR1N=1; ADDR=0; DIN=0; CPU_RDATA=0; CPU_ACK=0; BUSY=0.
//  RESET mid-transaction aborts it: strobes high next edge, no ACK issued, request is lost.
//  FSM states: IDLE, RD, WR, DONE.
//   IDLE: when CPU_REQ=1, register ADDR<=CPU_ADDR and the access attributes.
//         Write: DIN<=CPU_BYTE ? {CPU_WDATA[7:0],CPU_WDATA[7:0]} : CPU_WDATA; go to WR.
//         Read: go to RD. Load the wait counter with RD_WAIT or WR_WAIT.
//   RD: RDN=0 and counter decrements each cycle. On the last cycle (counter==1), sample DOUT and go to DONE.
//   WR: WR0N/WR1N low per lane for WR_WAIT cycles, then go to DONE.
//       Word write drives both low. Byte write drives WR0N low when HI=0, WR1N low when HI=1.
//   DONE: all strobes high, CPU_ACK=1 for exactly one cycle, go to IDLE.
//  Strobes are registered outputs. RDN and WRxN are never low in the same cycle.
//  ADDR/DIN stay stable for the whole strobe window and hold their value after it.
//  Read data formatting:
//   word read: CPU_RDATA=DOUT.
//   byte read: selected byte b=HI?DOUT[15:8]:DOUT[7:0]; CPU_RDATA = {SEXT&b[7] x8, b}.
//  CPU_RDATA is unchanged by writes.
//  Latency from REQ sampled in IDLE to ACK: read = RD_WAIT+2 cycles, write = WR_WAIT+2 cycles.
//  Back-to-back: REQ still high in the ACK cycle is not re-sampled. The next request is accepted in IDLE one cycle after ACK.
//  CPU_REQ or CPU inputs changing while BUSY are ignored; only the IDLE-sampled values count.
//  Unmapped addresses (memory returns 0) complete normally with CPU_RDATA=0 or sign/zero-extended 0.
// TESTING
//  1 Reset: assert RESET 2 cycles -> RDN=WR0N=WR1N=1, ADDR=0, ACK=0, BUSY=0.
//  2 Word write then read: write 0x2010<-0xBEEF, then read 0x2010.
//    -> WR0N=WR1N low for 1 cycle; read ACK 3 cycles after REQ with RDATA=0xBEEF.
//  3 Byte write HI=1 data 0x5A to 0x2010 -> only WR1N low, DIN=0x5A5A; word read returns 0x5AEF.
//  4 Byte reads of 0x2010 holding 0x80EF:
//    HI=1 SEXT=1 -> 0xFF80; HI=1 SEXT=0 -> 0x0080; HI=0 SEXT=1 -> 0xFFEF.
//  5 RD_WAIT=3 build: read -> RDN low exactly 3 cycles, ACK at cycle 5; REQ held through ACK gives no second ACK for 2 cycles.
//  6 RESET asserted in 2nd cycle of RDN low (RD_WAIT=3) -> RDN=1 next edge, no ACK, IDLE; following write completes normally.

Source files
------------

// File: rtl/mem_sequencer.sv
// mem_sequencer: CPU-side bus sequencer for a word-addressed RAM with
// separate byte-lane write strobes. One request per REQ/ACK handshake;
// address and write data are registered, strobes are timed by a wait
// counter, and byte reads are lane-selected and zero/sign-extended.
module mem_sequencer #(
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cpuReq,
    input  logic        i_cpuWe,
    input  logic        i_cpuByte,
    input  logic        i_cpuHi,
    input  logic        i_cpuSext,
    input  logic [15:0] i_cpuAddr,
    input  logic [15:0] i_cpuWdata,
    output logic [15:0] o_cpuRdata,
    output logic        o_cpuAck,
    output logic        o_busy,
    output logic [15:0] o_addr,
    output logic [15:0] o_din,
    input  logic [15:0] i_dout,
    output logic        o_rdn,
    output logic        o_wr0n,
    output logic        o_wr1n
);

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } stateT;

    stateT            r_state;
    stateT            w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nextCnt;

    logic [15:0] r_addr;
    logic [15:0] r_din;
    logic [15:0] r_rdata;
    logic        r_byte;
    logic        r_hi;
    logic        r_sext;
    logic        r_rdn;
    logic        r_wr0n;
    logic        r_wr1n;
    logic        r_ack;

    logic        w_rdnNext;
    logic        w_wr0nNext;
    logic        w_wr1nNext;
    logic        w_ackNext;
    logic        w_load;
    logic        w_capture;
    logic [7:0]  w_byteSel;
    logic [15:0] w_readData;

    // State register and wait counter; reset abandons any transaction in flight
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // Next-state logic plus the next values of the registered strobes and ACK
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_rdnNext   = 1'b1;
        w_wr0nNext  = 1'b1;
        w_wr1nNext  = 1'b1;
        w_ackNext   = 1'b0;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_cpuReq) begin
                    w_load = 1'b1;
                    if (i_cpuWe) begin
                        w_nextState = WR;
                        w_nextCnt   = WR_LOAD;
                        w_wr0nNext  = i_cpuByte & i_cpuHi;
                        w_wr1nNext  = i_cpuByte & ~i_cpuHi;
                    end else begin
                        w_nextState = RD;
                        w_nextCnt   = RD_LOAD;
                        w_rdnNext   = 1'b0;
                    end
                end
            end
            RD: begin
                if (r_cnt == CNT_ONE) begin
                    w_nextState = DONE;
                    w_capture   = 1'b1;
                    w_ackNext   = 1'b1;
                end else begin
                    w_nextCnt = r_cnt - CNT_ONE;
                    w_rdnNext = 1'b0;
                end
            end
            WR: begin
                if (r_cnt == CNT_ONE) begin
                    w_nextState = DONE;
                    w_ackNext   = 1'b1;
                end else begin
                    w_nextCnt  = r_cnt - CNT_ONE;
                    w_wr0nNext = r_wr0n;
                    w_wr1nNext = r_wr1n;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Strobes and ACK come straight from flops so the RAM sees glitch-free edges
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rdn  <= 1'b1;
            r_wr0n <= 1'b1;
            r_wr1n <= 1'b1;
            r_ack  <= 1'b0;
        end else begin
            r_rdn  <= w_rdnNext;
            r_wr0n <= w_wr0nNext;
            r_wr1n <= w_wr1nNext;
            r_ack  <= w_ackNext;
        end
    end

    // Request capture; address and data hold until the next accepted request
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr <= '0;
            r_din  <= '0;
            r_byte <= 1'b0;
            r_hi   <= 1'b0;
            r_sext <= 1'b0;
        end else if (w_load) begin
            r_addr <= i_cpuAddr;
            r_byte <= i_cpuByte;
            r_hi   <= i_cpuHi;
            r_sext <= i_cpuSext;
            if (i_cpuWe) begin
                r_din <= i_cpuByte ? {i_cpuWdata[7:0], i_cpuWdata[7:0]} : i_cpuWdata;
            end
        end
    end

    // Byte lane selection and zero/sign extension of the RAM output
    always_comb begin
        w_byteSel  = r_hi ? i_dout[15:8] : i_dout[7:0];
        w_readData = i_dout;
        if (r_byte) begin
            w_readData = {{8{r_sext & w_byteSel[7]}}, w_byteSel};
        end
    end

    // Read result register; only a completing read updates it
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rdata <= '0;
        end else if (w_capture) begin
            r_rdata <= w_readData;
        end
    end

    assign o_cpuRdata = r_rdata;
    assign o_cpuAck   = r_ack;
    assign o_busy     = (r_state != IDLE);
    assign o_addr     = r_addr;
    assign o_din      = r_din;
    assign o_rdn      = r_rdn;
    assign o_wr0n     = r_wr0n;
    assign o_wr1n     = r_wr1n;

endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: directed bench for mem_sequencer. Two instances share
// the CPU attribute inputs: dutA uses one-cycle waits, dutB a three-cycle
// read wait. Each has its own small RAM model mapped at 0x2000-0x20FF.
module tb_mem_sequencer;

    logic        clk;
    logic        resetA;
    logic        resetB;
    logic        reqA;
    logic        reqB;
    logic        we;
    logic        byteAcc;
    logic        hi;
    logic        sext;
    logic [15:0] cpuAddr;
    logic [15:0] cpuWdata;

    logic [15:0] rdataA, addrA, dinA, doutA;
    logic        ackA, busyA, rdnA, wr0nA, wr1nA;
    logic [15:0] rdataB, addrB, dinB, doutB;
    logic        ackB, busyB, rdnB, wr0nB, wr1nB;

    logic [15:0] memA [0:255];
    logic [15:0] memB [0:255];

    int nAsserts;
    int nFails;

    mem_sequencer #(.RD_WAIT(1), .WR_WAIT(1)) dutA (
        .i_clk(clk), .i_reset(resetA), .i_cpuReq(reqA), .i_cpuWe(we),
        .i_cpuByte(byteAcc), .i_cpuHi(hi), .i_cpuSext(sext),
        .i_cpuAddr(cpuAddr), .i_cpuWdata(cpuWdata),
        .o_cpuRdata(rdataA), .o_cpuAck(ackA), .o_busy(busyA),
        .o_addr(addrA), .o_din(dinA), .i_dout(doutA),
        .o_rdn(rdnA), .o_wr0n(wr0nA), .o_wr1n(wr1nA)
    );

    mem_sequencer #(.RD_WAIT(3), .WR_WAIT(1)) dutB (
        .i_clk(clk), .i_reset(resetB), .i_cpuReq(reqB), .i_cpuWe(we),
        .i_cpuByte(byteAcc), .i_cpuHi(hi), .i_cpuSext(sext),
        .i_cpuAddr(cpuAddr), .i_cpuWdata(cpuWdata),
        .o_cpuRdata(rdataB), .o_cpuAck(ackB), .o_busy(busyB),
        .o_addr(addrB), .o_din(dinB), .i_dout(doutB),
        .o_rdn(rdnB), .o_wr0n(wr0nB), .o_wr1n(wr1nB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM A write port: each lane is written on a rising edge while its strobe is low
    always @(posedge clk) begin
        if (addrA[15:8] == 8'h20) begin
            if (!wr0nA) memA[addrA[7:0]][7:0]  <= dinA[7:0];
            if (!wr1nA) memA[addrA[7:0]][15:8] <= dinA[15:8];
        end
    end

    // RAM A output register, clocked on the falling edge so data is ready for a one-cycle read strobe
    always @(negedge clk) begin
        if (!rdnA) doutA <= (addrA[15:8] == 8'h20) ? memA[addrA[7:0]] : 16'h0000;
    end

    // RAM B write port
    always @(posedge clk) begin
        if (addrB[15:8] == 8'h20) begin
            if (!wr0nB) memB[addrB[7:0]][7:0]  <= dinB[7:0];
            if (!wr1nB) memB[addrB[7:0]][15:8] <= dinB[15:8];
        end
    end

    // RAM B output register
    always @(negedge clk) begin
        if (!rdnB) doutB <= (addrB[15:8] == 8'h20) ? memB[addrB[7:0]] : 16'h0000;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%04h expected 0x%04h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic iWe, input logic iByte, input logic iHi,
                                 input logic iSext, input logic [15:0] iAddr,
                                 input logic [15:0] iWdata);
        we       = iWe;
        byteAcc  = iByte;
        hi       = iHi;
        sext     = iSext;
        cpuAddr  = iAddr;
        cpuWdata = iWdata;
    endtask

    // One-cycle-wait transaction on dutA: after return the bench sits in the ACK cycle
    task automatic txnA();
        reqA = 1'b1;
        tick();
        tick();
    endtask

    // Drop the request and let dutA return to IDLE
    task automatic endA();
        reqA = 1'b0;
        tick();
    endtask

    initial begin
        nAsserts = 0;
        nFails   = 0;
        resetA   = 1'b1;
        resetB   = 1'b1;
        reqA     = 1'b0;
        reqB     = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Reset held for two cycles
        tick();
        tick();
        checkOutput("rst rdn", rdnA, 1'b1);
        checkOutput("rst wr0n", wr0nA, 1'b1);
        checkOutput("rst wr1n", wr1nA, 1'b1);
        checkOutput("rst addr", addrA, 16'h0000);
        checkOutput("rst din", dinA, 16'h0000);
        checkOutput("rst ack", ackA, 1'b0);
        checkOutput("rst busy", busyA, 1'b0);
        checkOutput("rst rdata", rdataA, 16'h0000);
        checkOutput("rstB rdn", rdnB, 1'b1);
        checkOutput("rstB busy", busyB, 1'b0);
        resetA = 1'b0;
        resetB = 1'b0;
        tick();
        checkOutput("idle busy", busyA, 1'b0);

        // Word write 0x2010 <- 0xBEEF
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h2010, 16'hBEEF);
        reqA = 1'b1;
        tick();
        checkOutput("ww wr0n", wr0nA, 1'b0);
        checkOutput("ww wr1n", wr1nA, 1'b0);
        checkOutput("ww rdn", rdnA, 1'b1);
        checkOutput("ww din", dinA, 16'hBEEF);
        checkOutput("ww addr", addrA, 16'h2010);
        checkOutput("ww busy", busyA, 1'b1);
        tick();
        checkOutput("ww ack", ackA, 1'b1);
        checkOutput("ww wr0n end", wr0nA, 1'b1);
        checkOutput("ww wr1n end", wr1nA, 1'b1);
        endA();
        checkOutput("ww ack drop", ackA, 1'b0);
        checkOutput("ww din hold", dinA, 16'hBEEF);

        // Word read of 0x2010; address input changed while busy must be ignored
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h2010, 16'h0000);
        reqA = 1'b1;
        tick();
        checkOutput("wr rdn", rdnA, 1'b0);
        checkOutput("wr wr0n", wr0nA, 1'b1);
        checkOutput("wr ack early", ackA, 1'b0);
        cpuAddr = 16'h4000;
        tick();
        checkOutput("wr ack", ackA, 1'b1);
        checkOutput("wr rdata", rdataA, 16'hBEEF);
        checkOutput("wr addr hold", addrA, 16'h2010);
        checkOutput("wr rdn end", rdnA, 1'b1);
        endA();

        // Byte write HI=1 of 0x5A (upper bits of WDATA must not matter)
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h2010, 16'h335A);
        reqA = 1'b1;
        tick();
        checkOutput("bw wr1n", wr1nA, 1'b0);
        checkOutput("bw wr0n", wr0nA, 1'b1);
        checkOutput("bw din", dinA, 16'h5A5A);
        tick();
        checkOutput("bw ack", ackA, 1'b1);
        checkOutput("bw rdata kept", rdataA, 16'hBEEF);
        endA();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h2010, 16'h0000);
        txnA();
        checkOutput("bw readback", rdataA, 16'h5AEF);
        endA();

        // Make 0x2010 hold 0x80EF, then byte reads with each lane/extension
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h2010, 16'h0080);
        txnA();
        endA();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h2010, 16'h0000);
        txnA();
        checkOutput("br hi sext", rdataA, 16'hFF80);
        endA();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h2010, 16'h0000);
        txnA();
        checkOutput("br hi zext", rdataA, 16'h0080);
        endA();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'h2010, 16'h0000);
        txnA();
        checkOutput("br lo sext", rdataA, 16'hFFEF);
        endA();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h2010, 16'h0000);
        txnA();
        checkOutput("br lo zext", rdataA, 16'h00EF);
        endA();

        // Byte write HI=0 touches only the low lane
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h2010, 16'h0011);
        reqA = 1'b1;
        tick();
        checkOutput("bwlo wr0n", wr0nA, 1'b0);
        checkOutput("bwlo wr1n", wr1nA, 1'b1);
        tick();
        endA();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h2010, 16'h0000);
        txnA();
        checkOutput("bwlo readback", rdataA, 16'h8011);
        endA();

        // Unmapped address reads as zero
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h4000, 16'h0000);
        txnA();
        checkOutput("unmap ack", ackA, 1'b1);
        checkOutput("unmap word", rdataA, 16'h0000);
        endA();

        // dutB: write 0x2010 <- 0x1234
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h2010, 16'h1234);
        reqB = 1'b1;
        tick();
        checkOutput("B wr wr0n", wr0nB, 1'b0);
        tick();
        checkOutput("B wr ack", ackB, 1'b1);
        reqB = 1'b0;
        tick();

        // dutB read with RD_WAIT=3: RDN low three cycles, ACK in cycle 5 counting REQ as cycle 1
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h2010, 16'h0000);
        reqB = 1'b1;
        tick();
        checkOutput("B rd c2 rdn", rdnB, 1'b0);
        tick();
        checkOutput("B rd c3 rdn", rdnB, 1'b0);
        checkOutput("B rd c3 ack", ackB, 1'b0);
        tick();
        checkOutput("B rd c4 rdn", rdnB, 1'b0);
        checkOutput("B rd c4 ack", ackB, 1'b0);
        tick();
        checkOutput("B rd c5 rdn", rdnB, 1'b1);
        checkOutput("B rd c5 ack", ackB, 1'b1);
        checkOutput("B rd c5 rdata", rdataB, 16'h1234);
        tick();
        checkOutput("B rd c6 ack", ackB, 1'b0);
        checkOutput("B rd c6 busy", busyB, 1'b0);
        tick();
        checkOutput("B rd c7 ack", ackB, 1'b0);
        checkOutput("B rd c7 busy", busyB, 1'b1);
        checkOutput("B rd c7 rdn", rdnB, 1'b0);
        reqB = 1'b0;
        for (int i = 0; i < 20 && !ackB; i++) tick();
        checkOutput("B rd2 ack", ackB, 1'b1);
        tick();

        // Reset during the second RDN-low cycle aborts the read
        reqB = 1'b1;
        tick();
        checkOutput("B abort c2 rdn", rdnB, 1'b0);
        tick();
        checkOutput("B abort c3 rdn", rdnB, 1'b0);
        resetB = 1'b1;
        reqB   = 1'b0;
        tick();
        checkOutput("B abort rdn", rdnB, 1'b1);
        checkOutput("B abort busy", busyB, 1'b0);
        checkOutput("B abort ack", ackB, 1'b0);
        resetB = 1'b0;
        tick();
        checkOutput("B abort ack later", ackB, 1'b0);
        tick();
        checkOutput("B abort ack later2", ackB, 1'b0);

        // Following write on dutB completes normally
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h2020, 16'hCAFE);
        reqB = 1'b1;
        tick();
        checkOutput("B post wr0n", wr0nB, 1'b0);
        checkOutput("B post wr1n", wr1nB, 1'b0);
        checkOutput("B post din", dinB, 16'hCAFE);
        tick();
        checkOutput("B post ack", ackB, 1'b1);
        checkOutput("B post rdata", rdataB, 16'h0000);
        reqB = 1'b0;
        tick();
        checkOutput("B post idle", busyB, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
